riscv_harness_ctrl: RTL and testbench
=====================================

# riscv_harness_ctrl

Synthesisable boot-and-check controller for RV32I core bring-up, on FPGA and in simulation. Streams a program image into instruction memory through that memory's write port, holds the core in reset for a programmable settle time, then releases it. While the core runs, the block snoops data-memory writes and issues a sticky pass/fail/timeout verdict. Parameters set the image size, the pass/fail rule and the timeout.

## Interface
Parameters:
- DATA_WIDTH, 32, data/instruction word width
- ADDR_WIDTH, 32, memory address width
- LOAD_WORDS, 32, words in the program image (≥1)
- RESET_HOLD, 2, cycles the core is held in reset after load completes (≥1)
- TIMEOUT_CYCLES, 1200, run cycles before timeout verdict (≥2)
- PASS_ADDR, 100, data address whose write signals success
- PASS_DATA, 25, value that must be written to PASS_ADDR for pass
- SCRATCH_ADDR, 96, the one other data address the program may write without failing

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  begin (or restart) a load/run session
- i_ld_valid  in  1  image word valid
- i_ld_data  in  DATA_WIDTH  image word
- o_ld_ready  out  1  block accepts an image word
- o_imem_sel  out  1  1 = harness owns the instruction-memory address/write port
- o_imem_we  out  1  instruction-memory write enable
- o_imem_addr  out  ADDR_WIDTH  word index being written
- o_imem_wdata  out  DATA_WIDTH  word being written
- o_imem_ctrl  out  4  byte enables; 4'b1111 whenever o_imem_we=1, else 4'b0000
- o_core_rst_n  out  1  core reset, active low
- i_dmem_we  in  1  snooped data write enable
- i_dmem_addr  in  ADDR_WIDTH  snooped data address
- i_dmem_wdata  in  DATA_WIDTH  snooped write data
- o_done, o_pass, o_fail, o_timeout  out  1 each  verdict flags, sticky
- o_fail_addr  out  ADDR_WIDTH  address of the offending write
- o_cycles  out  32  run-cycle count, saturating

## Operation
- FSM states: IDLE → LOAD → HOLD → RUN → {PASS, FAIL, TIMEOUT}.
- IDLE:
  - o_core_rst_n=0, o_imem_sel=1.
  - i_start=1 → LOAD; word counter and cycle counter cleared.
- LOAD:
  - o_ld_ready=1.
  - Each i_ld_valid&o_ld_ready accepts one word at index n = 0..LOAD_WORDS-1.
  - i_ld_valid low → stall, no write.
  - Accepting word LOAD_WORDS-1 → HOLD.
- HOLD:
  - o_imem_sel=0, o_core_rst_n=0.
  - Counts RESET_HOLD cycles, then → RUN.
- RUN:
  - o_core_rst_n=1; o_cycles increments every cycle.
  - On i_dmem_we=1, priority order:
    - addr==PASS_ADDR && wdata==PASS_DATA → PASS.
    - addr!=SCRATCH_ADDR → FAIL; o_fail_addr latched. This includes a write to PASS_ADDR with wrong data.
    - Writes to SCRATCH_ADDR are ignored.
  - No verdict and o_cycles==TIMEOUT_CYCLES-1 → TIMEOUT.
- Terminal states:
  - o_done=1 plus exactly one of o_pass/o_fail/o_timeout.
  - o_core_rst_n=0 (core frozen); o_imem_sel=1.
  - o_cycles and o_fail_addr hold their values.
  - i_start=1 → LOAD with all flags cleared.
- i_start is ignored in LOAD/HOLD/RUN.
- i_dmem_* is ignored outside RUN.

## Timing
- Reset (async assert, sync release) → IDLE.
  - All outputs 0, except o_imem_sel=1 and o_imem_ctrl=0.
- Image writes are registered:
  - Handshake at edge k → o_imem_we=1, o_imem_addr=n (zero-extended), o_imem_wdata=word during cycle k+1.
  - Maximum rate is one word per cycle.
- The last write (index LOAD_WORDS-1) is presented in the first HOLD cycle, with o_imem_sel still 1.
  - o_imem_sel drops one cycle after that.
  - HOLD therefore lasts RESET_HOLD+1 cycles.
- o_core_rst_n rises on the edge entering RUN. o_cycles=0 in the first RUN cycle.
- Verdict flags assert on the edge following the qualifying snooped write. That write is sampled combinationally at the edge.
- Same-cycle qualifying write and timeout → the write verdict wins.
- rst_n asserted mid-LOAD or mid-RUN → immediate IDLE. A partial image is left in memory; no write is completed.

## Structure
- Add to package riscv_definitions:
  - harness_state_t enum (IDLE, LOAD, HOLD, RUN, PASS, FAIL, TIMEOUT).
  - verdict_t {NONE, PASS, FAIL, TIMEOUT}.
  - Widths from the existing DATA_WIDTH.
- Sub-module harness_write_checker: combinational classification of the snooped write into verdict_t, parameterised by PASS_ADDR/PASS_DATA/SCRATCH_ADDR.
- The top level holds the FSM, the word/hold/cycle counters and the output registers.
- The existing instruction-memory address mux is driven by o_imem_sel.

## Test plan
- LOAD_WORDS=4, words A0..A3 streamed back-to-back → four writes at addr 0..3 with ctrl 4'b1111; o_core_rst_n rises 3 cycles after the last write (RESET_HOLD=2).
- Image stream with i_ld_valid gaps of 2 cycles → no writes during gaps; addresses stay contiguous; HOLD entered only after the 4th accept.
- RUN: write 96←7, then 100←25 → o_pass=1 and o_done=1 one cycle later; o_core_rst_n=0; o_fail stays 0.
- RUN: write 100←24 → o_fail=1, o_fail_addr=100; a write to 200 → o_fail=1, o_fail_addr=200.
- TIMEOUT_CYCLES=10, no snooped writes → o_timeout after 10 run cycles, o_cycles=9; a write of 100←25 in that same cycle → o_pass instead.
- rst_n pulsed low mid-LOAD at word 2 → all outputs at reset values immediately; i_start then reloads from addr 0.

Source files
------------

// File: rtl/riscv_definitions.sv
// riscv_definitions: shared widths and enums for the RV32I bring-up harness
package riscv_definitions;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} harness_state_t;
  typedef enum logic [1:0] {V_NONE, V_PASS, V_FAIL, V_TIMEOUT} verdict_t;
endpackage

// File: rtl/harness_write_checker.sv
// harness_write_checker: classifies one snooped data-memory write into a verdict
module harness_write_checker
  import riscv_definitions::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = XLEN,
  parameter logic [ADDR_WIDTH-1:0] PASS_ADDR = ADDR_WIDTH'(100),
  parameter logic [DATA_WIDTH-1:0] PASS_DATA = DATA_WIDTH'(25),
  parameter logic [ADDR_WIDTH-1:0] SCRATCH_ADDR = ADDR_WIDTH'(96)
) (
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output verdict_t              verdict
);
  // a wrong value written to PASS_ADDR falls through to the fail rule
  assign verdict = !we ? V_NONE :
                   (addr == PASS_ADDR && wdata == PASS_DATA) ? V_PASS :
                   addr != SCRATCH_ADDR ? V_FAIL : V_NONE;
endmodule

// File: rtl/riscv_harness_ctrl.sv
// riscv_harness_ctrl: loads an image into imem, releases the core, and snoops dmem for a verdict
module riscv_harness_ctrl
  import riscv_definitions::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = XLEN,
  parameter int LOAD_WORDS = 32,
  parameter int RESET_HOLD = 2,
  parameter int TIMEOUT_CYCLES = 1200,
  parameter logic [ADDR_WIDTH-1:0] PASS_ADDR = ADDR_WIDTH'(100),
  parameter logic [DATA_WIDTH-1:0] PASS_DATA = DATA_WIDTH'(25),
  parameter logic [ADDR_WIDTH-1:0] SCRATCH_ADDR = ADDR_WIDTH'(96)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_ld_valid,
  input  logic [DATA_WIDTH-1:0] i_ld_data,
  output logic                  o_ld_ready,
  output logic                  o_imem_sel,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [DATA_WIDTH-1:0] o_imem_wdata,
  output logic [3:0]            o_imem_ctrl,
  output logic                  o_core_rst_n,
  input  logic                  i_dmem_we,
  input  logic [ADDR_WIDTH-1:0] i_dmem_addr,
  input  logic [DATA_WIDTH-1:0] i_dmem_wdata,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_fail,
  output logic                  o_timeout,
  output logic [ADDR_WIDTH-1:0] o_fail_addr,
  output logic [31:0]           o_cycles
);
  harness_state_t state, nxt;
  verdict_t verdict;
  logic [31:0] wcnt, hold_cnt;
  logic accept, restart;

  harness_write_checker #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .PASS_ADDR(PASS_ADDR), .PASS_DATA(PASS_DATA), .SCRATCH_ADDR(SCRATCH_ADDR)
  ) u_chk (
    .we(i_dmem_we), .addr(i_dmem_addr), .wdata(i_dmem_wdata), .verdict(verdict)
  );

  assign accept  = state == S_LOAD && i_ld_valid;
  assign restart = nxt == S_LOAD && state != S_LOAD;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = i_start ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = (accept && wcnt == 32'(LOAD_WORDS - 1)) ? S_HOLD : S_LOAD;
      S_HOLD:  nxt = hold_cnt == 32'(RESET_HOLD) ? S_RUN : S_HOLD;
      S_RUN:   nxt = verdict == V_PASS ? S_PASS :
                     verdict == V_FAIL ? S_FAIL :
                     o_cycles == 32'(TIMEOUT_CYCLES - 1) ? S_TIMEOUT : S_RUN;
      default: nxt = i_start ? S_LOAD : state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wcnt         <= '0;
      hold_cnt     <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_fail_addr  <= '0;
      o_cycles     <= '0;
    end else begin
      state     <= nxt;
      o_imem_we <= accept;
      hold_cnt  <= state == S_HOLD ? hold_cnt + 32'd1 : '0;
      if (accept) begin
        o_imem_addr  <= ADDR_WIDTH'(wcnt);
        o_imem_wdata <= i_ld_data;
        wcnt         <= wcnt + 32'd1;
      end
      if (state == S_RUN && nxt == S_RUN && o_cycles != '1) o_cycles <= o_cycles + 32'd1;
      if (state == S_RUN && nxt == S_FAIL) o_fail_addr <= i_dmem_addr;
      if (restart) begin
        wcnt        <= '0;
        o_cycles    <= '0;
        o_fail_addr <= '0;
      end
    end
  end

  // the last image write lands in the first HOLD cycle, so the port is released one cycle later
  assign o_imem_sel   = !(state == S_RUN || (state == S_HOLD && !o_imem_we));
  assign o_imem_ctrl  = {4{o_imem_we}};
  assign o_ld_ready   = state == S_LOAD;
  assign o_core_rst_n = state == S_RUN;
  assign o_pass       = state == S_PASS;
  assign o_fail       = state == S_FAIL;
  assign o_timeout    = state == S_TIMEOUT;
  assign o_done       = o_pass | o_fail | o_timeout;
endmodule

// File: tb/tb_riscv_harness_ctrl.sv
// tb_riscv_harness_ctrl: scoreboard bench for the boot-and-check harness controller
module tb_riscv_harness_ctrl;
  localparam int LW = 4;
  localparam int RH = 2;
  localparam int TO = 10;

  logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_ld_valid = 1'b0, i_dmem_we = 1'b0;
  logic [31:0] i_ld_data = '0, i_dmem_addr = '0, i_dmem_wdata = '0;
  logic o_ld_ready, o_imem_sel, o_imem_we, o_core_rst_n, o_done, o_pass, o_fail, o_timeout;
  logic [31:0] o_imem_addr, o_imem_wdata, o_fail_addr, o_cycles;
  logic [3:0] o_imem_ctrl;

  riscv_harness_ctrl #(.LOAD_WORDS(LW), .RESET_HOLD(RH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_ld_valid(i_ld_valid), .i_ld_data(i_ld_data),
    .o_ld_ready(o_ld_ready), .o_imem_sel(o_imem_sel), .o_imem_we(o_imem_we),
    .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata), .o_imem_ctrl(o_imem_ctrl),
    .o_core_rst_n(o_core_rst_n), .i_dmem_we(i_dmem_we), .i_dmem_addr(i_dmem_addr),
    .i_dmem_wdata(i_dmem_wdata), .o_done(o_done), .o_pass(o_pass), .o_fail(o_fail),
    .o_timeout(o_timeout), .o_fail_addr(o_fail_addr), .o_cycles(o_cycles)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic p; logic f; logic t; logic [31:0] fa; logic [31:0] cyc; } vd_t;
  wr_t wr_q[$];
  vd_t vd_q[$];
  wr_t wr_exp;
  vd_t vd_exp;
  int vectors = 0, miscompares = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: imem writes and verdict onsets are matched against the queues
  always @(negedge clk) begin
    if (rst_n && o_imem_we) begin
      if (wr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", o_imem_addr, o_imem_wdata);
      end else begin
        wr_exp = wr_q.pop_front();
        chk("imem_addr", 64'(o_imem_addr), 64'(wr_exp.addr));
        chk("imem_wdata", 64'(o_imem_wdata), 64'(wr_exp.data));
        chk("imem_ctrl", 64'(o_imem_ctrl), 64'h f);
        chk("imem_sel_on_write", 64'(o_imem_sel), 64'd1);
      end
    end
    if (rst_n && o_done && !prev_done) begin
      if (vd_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_verdict: got p%0b f%0b t%0b expected none", o_pass, o_fail, o_timeout);
      end else begin
        vd_exp = vd_q.pop_front();
        chk("pass", 64'(o_pass), 64'(vd_exp.p));
        chk("fail", 64'(o_fail), 64'(vd_exp.f));
        chk("timeout", 64'(o_timeout), 64'(vd_exp.t));
        chk("fail_addr", 64'(o_fail_addr), 64'(vd_exp.fa));
        chk("cycles", 64'(o_cycles), 64'(vd_exp.cyc));
        chk("core_frozen", 64'(o_core_rst_n), 64'd0);
        chk("sel_terminal", 64'(o_imem_sel), 64'd1);
      end
    end
    prev_done = o_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    chk("rst_ld_ready", 64'(o_ld_ready), 64'd0);
    chk("rst_sel", 64'(o_imem_sel), 64'd1);
    chk("rst_we", 64'(o_imem_we), 64'd0);
    chk("rst_addr", 64'(o_imem_addr), 64'd0);
    chk("rst_wdata", 64'(o_imem_wdata), 64'd0);
    chk("rst_ctrl", 64'(o_imem_ctrl), 64'd0);
    chk("rst_core", 64'(o_core_rst_n), 64'd0);
    chk("rst_flags", 64'({o_done, o_pass, o_fail, o_timeout}), 64'd0);
    chk("rst_fail_addr", 64'(o_fail_addr), 64'd0);
    chk("rst_cycles", 64'(o_cycles), 64'd0);
  endtask

  task automatic start_session();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic push_word(input int n, input logic [31:0] d);
    wr_q.push_back('{addr: 32'(n), data: d});
    i_ld_valid = 1'b1;
    i_ld_data  = d;
    tick();
    i_ld_valid = 1'b0;
  endtask

  task automatic load_image(input int gap, input logic [31:0] base);
    for (int n = 0; n < LW; n++) begin
      push_word(n, base + 32'(n));
      if (n < LW - 1)
        for (int g = 0; g < gap; g++) begin
          chk("ready_in_gap", 64'(o_ld_ready), 64'd1);
          tick();
        end
    end
  endtask

  // entered one cycle after the last accept; exits in the first RUN cycle
  task automatic to_run();
    chk("sel_last_write", 64'(o_imem_sel), 64'd1);
    chk("ready_hold", 64'(o_ld_ready), 64'd0);
    tick();
    chk("sel_hold", 64'(o_imem_sel), 64'd0);
    chk("core_hold1", 64'(o_core_rst_n), 64'd0);
    tick();
    chk("core_hold2", 64'(o_core_rst_n), 64'd0);
    tick();
    chk("core_run", 64'(o_core_rst_n), 64'd1);
    chk("cycles_first_run", 64'(o_cycles), 64'd0);
  endtask

  task automatic snoop(input logic [31:0] a, input logic [31:0] d);
    i_dmem_we    = 1'b1;
    i_dmem_addr  = a;
    i_dmem_wdata = d;
    tick();
    i_dmem_we = 1'b0;
  endtask

  task automatic expect_verdict(input logic p, input logic f, input logic t,
                                input logic [31:0] fa, input logic [31:0] cyc);
    vd_q.push_back('{p: p, f: f, t: t, fa: fa, cyc: cyc});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check_reset();
    rst_n = 1'b1;
    tick();
    // back-to-back load, scratch write then pass
    start_session();
    load_image(0, 32'h A0);
    to_run();
    snoop(32'd96, 32'd7);
    expect_verdict(1'b1, 1'b0, 1'b0, 32'd0, 32'd1);
    snoop(32'd100, 32'd25);
    chk("pass_core", 64'(o_core_rst_n), 64'd0);
    chk("pass_no_fail", 64'(o_fail), 64'd0);
    snoop(32'd200, 32'd1);
    chk("ignored_outside_run", 64'({o_done, o_pass, o_fail}), 64'b110);
    // gapped load, wrong data at pass address
    start_session();
    chk("restart_clears", 64'(o_done), 64'd0);
    load_image(2, 32'h B0);
    to_run();
    expect_verdict(1'b0, 1'b1, 1'b0, 32'd100, 32'd0);
    snoop(32'd100, 32'd24);
    // stray write after two run cycles
    start_session();
    load_image(0, 32'h C0);
    to_run();
    tick();
    tick();
    expect_verdict(1'b0, 1'b1, 1'b0, 32'd200, 32'd2);
    snoop(32'd200, 32'd5);
    // timeout, then pass winning in the timeout cycle
    start_session();
    load_image(0, 32'h D0);
    to_run();
    expect_verdict(1'b0, 1'b0, 1'b1, 32'd0, 32'd9);
    repeat (TO) tick();
    chk("timeout_flag", 64'(o_timeout), 64'd1);
    start_session();
    load_image(1, 32'h E0);
    to_run();
    repeat (TO - 1) tick();
    expect_verdict(1'b1, 1'b0, 1'b0, 32'd0, 32'd9);
    snoop(32'd100, 32'd25);
    chk("pass_beats_timeout", 64'(o_timeout), 64'd0);
    // async reset mid-load at word 2
    start_session();
    push_word(0, 32'h 11);
    push_word(1, 32'h 22);
    i_ld_valid = 1'b1;
    i_ld_data  = 32'h 33;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset();
    i_ld_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    start_session();
    load_image(0, 32'h F0);
    to_run();
    tick();
    chk("write_queue_empty", 64'(wr_q.size()), 64'd0);
    chk("verdict_queue_empty", 64'(vd_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
